// File: rtl/mux_4_1_rr_stream.sv
// mux_4_1_rr_stream: 4:1 valid/ready stream merge with round-robin arbitration
// and one registered output stage. The source channel index travels with each
// beat on sel_o so a downstream 1:4 demux can steer the response back.
// Optional build macro MUX_PKT_LOCK_EN: hold the grant on one channel from the
// first beat of a packet until its in_last beat, so packets never interleave.
module mux_4_1_rr_stream #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  input  logic [3:0]     in_last,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [1:0]     sel_o,
  input  logic           out_ready
);

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  // Output stage and arbitration pointer
  logic          valid_q, valid_d;
  logic [W-1:0]  data_q,  data_d;
  logic          last_q,  last_d;
  logic [IW-1:0] sel_q,   sel_d;
  logic [IW-1:0] ptr_q,   ptr_d;

`ifdef MUX_PKT_LOCK_EN
  typedef enum logic {LK_OPEN, LK_HELD} lock_e;
  lock_e         lock_st_q, lock_st_d;
  logic [IW-1:0] lock_ch_q, lock_ch_d;
`endif

  // Arbitration scratch
  logic [N-1:0]  eligible_c;
  logic [N-1:0]  grant_c;
  logic [IW-1:0] gidx_c;
  logic [IW-1:0] idx_c;
  logic          found_c;
  logic [W-1:0]  gdata_c;
  logic          glast_c;
  logic          load_c;
  logic          take_c;

  // Output register may accept a new beat when empty or being drained
  assign load_c = !valid_q | out_ready;

  // Round-robin scan from ptr; lock (if built in) restricts the candidate set
  always_comb begin
    eligible_c = in_valid;
`ifdef MUX_PKT_LOCK_EN
    if (lock_st_q == LK_HELD) begin
      eligible_c = in_valid & (N'(1) << lock_ch_q);
    end
`endif
    grant_c = '0;
    gidx_c  = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx_c = ptr_q + IW'(i);
      if (!found_c && eligible_c[idx_c]) begin
        grant_c[idx_c] = 1'b1;
        gidx_c         = idx_c;
        found_c        = 1'b1;
      end
    end
  end

  // Payload of the granted channel
  always_comb begin
    gdata_c = '0;
    glast_c = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant_c[k]) begin
        gdata_c = in_data[k*W +: W];
        glast_c = in_last[k];
      end
    end
  end

  // Nothing is accepted on an edge that carries reset
  assign take_c   = load_c & (|grant_c) & !rst;
  assign in_ready = (load_c && !rst) ? grant_c : '0;

  // Next state for output stage, pointer and lock
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef MUX_PKT_LOCK_EN
    lock_st_d = lock_st_q;
    lock_ch_d = lock_ch_q;
`endif
    if (load_c) begin
      if (take_c) begin
        valid_d = 1'b1;
        data_d  = gdata_c;
        last_d  = glast_c;
        sel_d   = gidx_c;
`ifdef MUX_PKT_LOCK_EN
        if (glast_c) begin
          lock_st_d = LK_OPEN;
          ptr_d     = gidx_c + IW'(1);
        end else begin
          lock_st_d = LK_HELD;
          lock_ch_d = gidx_c;
        end
`else
        ptr_d   = gidx_c + IW'(1);
`endif
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef MUX_PKT_LOCK_EN
      lock_st_q <= LK_OPEN;
      lock_ch_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef MUX_PKT_LOCK_EN
      lock_st_q <= lock_st_d;
      lock_ch_q <= lock_ch_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign sel_o     = sel_q;

endmodule

// File: tb/tb_mux_4_1_rr_stream.sv
// Directed bench for mux_4_1_rr_stream (default build or MUX_PKT_LOCK_EN build).
module tb_mux_4_1_rr_stream;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  sel_o;
  logic        out_ready;

  int errors;
  int checks;

  mux_4_1_rr_stream #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .sel_o     (sel_o),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are then driven and outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b0; in_data = '0; in_last = 4'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    checks++; if (sel_o !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel_o); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    logic [1:0] exp_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    in_data = 32'hA3A2A1A0; in_last = 4'b1111; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got=%b exp=0001", in_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || sel_o !== exp_s[i]) begin
        errors++;
        $display("FAIL rr_beat%0d got v=%b d=%h s=%0d exp v=1 d=%h s=%0d", i, out_valid, out_data, sel_o, exp_d[i], exp_s[i]);
      end
    end
    in_valid = 4'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    // ptr is 1 here; only ch2 valid
    in_data = 32'h00550000; in_last = 4'b1111; in_valid = 4'b0100; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_capture_ready got=%b exp=0100", in_ready); end
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_held%0d got=%b exp=0000", i, in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55 || sel_o !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h s=%0d exp v=1 d=55 s=2", i, out_valid, out_data, sel_o);
      end
      step();
    end
    in_valid = 4'b0010; in_data = 32'h00001100; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || sel_o !== 2'd1) begin
      errors++;
      $display("FAIL bp_no_bubble got v=%b d=%h s=%0d exp v=1 d=11 s=1", out_valid, out_data, sel_o);
    end
    in_valid = 4'b0;
    step();
  endtask

  task automatic test_wrap();
    // grant ch2 so ptr becomes 3
    in_data = 32'h00220000; in_last = 4'b1111; in_valid = 4'b0100; out_ready = 1'b1;
    step();
    checks++; if (sel_o !== 2'd2) begin errors++; $display("FAIL wrap_setup got=%0d exp=2", sel_o); end
    in_data = 32'h330000C0; in_valid = 4'b1001;
    #1;
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready got=%b exp=1000", in_ready); end
    step();
    checks++;
    if (sel_o !== 2'd3 || out_data !== 8'h33) begin errors++; $display("FAIL wrap_ch3 got s=%0d d=%h exp s=3 d=33", sel_o, out_data); end
    step();
    checks++;
    if (sel_o !== 2'd0 || out_data !== 8'hC0) begin errors++; $display("FAIL wrap_ch0 got s=%0d d=%h exp s=0 d=C0", sel_o, out_data); end
    in_valid = 4'b0;
    step();
  endtask

  task automatic test_reset_mid();
    in_data = 32'h00007700; in_last = 4'b1111; in_valid = 4'b0010; out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || sel_o !== 2'd1) begin errors++; $display("FAIL rstmid_setup got v=%b s=%0d exp v=1 s=1", out_valid, sel_o); end
    rst = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rstmid_ready got=%b exp=0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || sel_o !== 2'd0) begin errors++; $display("FAIL rstmid_flush got v=%b s=%0d exp v=0 s=0", out_valid, sel_o); end
    rst = 1'b0; in_valid = 4'b1111; in_data = 32'hD3D2D1D0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_prio got=%b exp=0001", in_ready); end
    step();
    checks++; if (sel_o !== 2'd0 || out_data !== 8'hD0) begin errors++; $display("FAIL rstmid_first got s=%0d d=%h exp s=0 d=D0", sel_o, out_data); end
    in_valid = 4'b0;
    step();
  endtask

  task automatic test_packet();
`ifdef MUX_PKT_LOCK_EN
    logic [1:0] exp_s [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    logic       exp_l [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    logic [1:0] exp_s [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic       exp_l [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    int cnt0;
    cnt0 = 0;
    rst = 1'b1; in_valid = 4'b0; out_ready = 1'b1;
    step();
    rst = 1'b0;
    in_data = 32'h0000E1E0;
    for (int i = 0; i < 4; i++) begin
      in_valid   = {2'b00, 1'b1, (cnt0 < 3)};
      in_last    = {3'b001, (cnt0 == 2)};
      step();
      checks++;
      if (out_valid !== 1'b1 || sel_o !== exp_s[i] || out_last !== exp_l[i]) begin
        errors++;
        $display("FAIL pkt_beat%0d got v=%b s=%0d l=%b exp v=1 s=%0d l=%b", i, out_valid, sel_o, out_last, exp_s[i], exp_l[i]);
      end
      if (exp_s[i] == 2'd0) cnt0++;
    end
    in_valid = 4'b0;
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
